if_id_buf: RTL
==============

Name: if_id_buf

Overview:
- Parametrised successor to the IF/ID stage register.
- Replaces the single pc/inst latch with a DEPTH-entry in-order buffer between fetch and decode.
- Fetch pushes using a valid/ready handshake. Decode pops unless the ctrl module stalls it.
- Flush discards all buffered entries, so fetch can run ahead of short decode stalls without losing instructions.

Parameters:
- PC_W, 32, width of instruction address.
- INST_W, 32, width of instruction word.
- DEPTH, 2, buffer entries; must be a power of 2, range 2..8.
- CTRL_W, 6, width of ctrl_signal.
- STAGE_IDX, 1, bit of ctrl_signal that stalls fetch; bit STAGE_IDX+1 stalls decode.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ctrl_signal  in  CTRL_W  stall vector from ctrl module.
- flush  in  1  discard all buffered entries (branch/exception redirect).
- if_valid  in  1  fetch presents pc/inst.
- if_ready  out  1  buffer accepts this cycle.
- if_pc  in  PC_W  fetched instruction address.
- if_inst  in  INST_W  fetched instruction word.
- id_valid  out  1  head entry valid.
- id_pc  out  PC_W  head address; 0 when empty.
- id_inst  out  INST_W  head instruction; 0 (NOP) when empty.
- count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- Storage: DEPTH entries of {pc, inst}, read pointer rd_ptr, write pointer wr_ptr (log2(DEPTH) bits, natural wrap), occupancy counter count (0..DEPTH).
- Reset, when rst==0 at a clock edge:
  - count=0, both pointers 0, all entries zeroed.
  - id_valid=0, id_pc=0, id_inst=0.
  - if_ready reflects the reset state (1) from the next cycle.
- if_ready (combinational) = (count != DEPTH) && (ctrl_signal[STAGE_IDX]==0) && !flush.
- push = if_valid && if_ready. Writes {if_pc, if_inst} to entry wr_ptr; wr_ptr increments.
- pop = id_valid && (ctrl_signal[STAGE_IDX+1]==0). rd_ptr increments.
- Output timing:
  - id_valid = (count != 0).
  - id_pc/id_inst = entry[rd_ptr] when id_valid, else 0 (bubble, decodes as NOP). Outputs are purely a function of registers.
- Latency: a push at edge N into an empty buffer is presented on id_* after edge N. No same-cycle fall-through.
- Count update: push only +1; pop only -1; push and pop together leave count unchanged and both pointers advance.
- Full: if_ready=0 even if a pop occurs the same cycle (no full-bypass). count never exceeds DEPTH.
- Empty: no pop. Decode sees zeros and id_valid=0.
- Decode stall: ctrl_signal[STAGE_IDX+1]=1 holds the head entry stable; pushes continue until full.
- Fetch stall only: ctrl_signal[STAGE_IDX]=1 with bit STAGE_IDX+1=0 blocks pushes while pops drain. When the buffer empties, decode receives bubbles. This is the generalisation of the old "fetch stalled, decode not" NOP insertion.
- Flush:
  - Priority over push, pop and stalls.
  - At the edge: count=0, rd_ptr=wr_ptr=0. Entry contents are don't-care.
  - After the edge: id_valid=0, id_pc=0, id_inst=0.
  - if_ready is 0 in the flush cycle; the redirected fetch is accepted from the next cycle.
- Priority order: reset > flush > push/pop.
- Reset or flush mid-operation loses all entries; no partial state survives.

Decomposition:
- Shared defines file additions: reset-active level constant for active-low reset, ZeroWord, NOP instruction encoding, default ctrl stage indices for IF and ID.
- No typedefs needed.
- No sub-module: storage, pointers and counter stay inline. A separate FIFO would obscure the flush/bubble semantics.

Test Plan:
- Reset: hold rst=0 for 2 edges with if_valid=1 and data present -> id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1 on the cycle after release.
- Streaming, no stalls: push pc 0x0,0x4,0x8 with insts 0x11,0x22,0x33 on consecutive cycles -> each appears on id_* exactly one cycle after push, in order; count stays 1.
- Fill: hold ctrl_signal=6'b000100, push 0x10,0x14,0x18 (DEPTH=2) -> count=2 after two pushes, if_ready=0, third held by fetch. Head stays 0x10 throughout the stall. Release the stall -> 0x10,0x14,0x18 emerge in order.
- Fetch-only stall: buffer holds 1 entry (pc 0x20), ctrl_signal=6'b000010 -> entry 0x20 popped, next cycle id_valid=0 and id_pc=id_inst=0, if_ready=0.
- Flush with simultaneous push/pop: count=2, assert flush with if_valid=1 and no stalls -> after the edge count=0, id_valid=0, outputs zero. The flush-cycle push is not accepted. A push of 0x100 next cycle appears one cycle later.
- Wrap-around with DEPTH=4: 10 push/pop cycles with varying decode stalls -> output sequence equals input sequence and count matches the scoreboard every cycle.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared constants for the fetch/decode instruction buffer: reset level,
// zero/NOP encodings driven during bubbles, and default stall-vector indices.
package if_id_buf_pkg;

    // Reset is active-low: the block resets when rst equals this level.
    localparam logic        RST_ENABLE = 1'b0;

    // Value driven on the decode-side address when no entry is presented.
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Instruction word driven during a bubble; decodes as a NOP.
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    // Default bit positions in the ctrl stall vector for fetch and decode.
    localparam int          STAGE_IF   = 1;
    localparam int          STAGE_ID   = 2;

endpackage : if_id_buf_pkg

// File: rtl/if_id_buf.sv
// In-order buffer between fetch and decode. Fetch pushes with a valid/ready
// handshake, decode pops the head unless stalled, and flush empties the buffer
// so a redirected fetch stream starts clean. Decode sees zeros (a NOP bubble)
// whenever the buffer is empty.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int INST_W    = 32,
    parameter int DEPTH     = 2,
    parameter int CTRL_W    = 6,
    parameter int STAGE_IDX = STAGE_IF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        ctrl_signal,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [PC_W-1:0]          if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     id_valid,
    output logic [PC_W-1:0]          id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int DEC_IDX = STAGE_IDX + 1;

    // Storage and bookkeeping state.
    logic [PC_W-1:0]   pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Handshake decisions for the current cycle.
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;

    // Only the fetch and decode bits of the stall vector matter here; the
    // reduction keeps the remaining bits visibly consumed.
    logic              ctrl_unused_s;
    assign ctrl_unused_s = ^ctrl_signal;

    // Handshake: ready excludes full (no bypass on a same-cycle pop), fetch
    // stall and flush; a pop needs a valid head and no decode stall.
    always_comb begin
        full_s   = (count_r == CNT_W'(DEPTH));
        empty_s  = (count_r == {CNT_W{1'b0}});
        if_ready = !full_s && !ctrl_signal[STAGE_IDX] && !flush;
        push_s   = if_valid && if_ready;
        pop_s    = !empty_s && !ctrl_signal[DEC_IDX];
    end

    // Decode-side view: head entry when occupied, otherwise a zero bubble.
    always_comb begin
        id_valid = !empty_s;
        count    = count_r;
        if (!empty_s) begin
            id_pc   = pc_mem_r[rd_ptr_r];
            id_inst = inst_mem_r[rd_ptr_r];
        end else begin
            id_pc   = PC_W'(ZERO_WORD);
            id_inst = INST_W'(NOP_INST);
        end
    end

    // Entry storage: cleared on reset, written at the write pointer on push.
    // Flush leaves contents alone; they become unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {PC_W{1'b0}};
                inst_mem_r[i] <= {INST_W{1'b0}};
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= if_pc;
            inst_mem_r[wr_ptr_r] <= if_inst;
        end else begin
            pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
            inst_mem_r[wr_ptr_r] <= inst_mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : if_id_buf
